pipe_sram_target: RTL

Single-port on-chip SRAM that acts as the responder end of a pipeconnect `REQ`/`RES` link, serving the requests the core issues on its `imem`, `dmem` or `peripherals` ports. It inserts a programmable number of wait states by asserting `HOLD`, performs byte-masked writes, and returns read data one cycle after acceptance. It is intended both as a boot/scratch RAM in the SoC and as a configurable-latency memory model for core verification.

---
 rtl/pipe_sram_target.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pipe_sram_target.sv
`default_nettype none
// ============================================================================
// Module      : pipe_sram_target
// Description : Single-port 32-bit SRAM responder for a pipeconnect REQ/RES
//               link. Inserts WAIT_STATES cycles of HOLD per request,
//               performs byte-masked writes and returns read data with a
//               one-cycle RDV pulse after acceptance.
// Options     : `define PIPE_SRAM_BOUNDS_EN to drop writes outside the BASE
//               window and answer out-of-window reads with 32'hDEADBEEF.
// Revision    : 1.0 - initial release
// ============================================================================

package pipe_sram_pkg;

  typedef struct packed {
    logic [31:0] A;
    logic        R;
    logic        W;
    logic [31:0] WD;
    logic [3:0]  WBE;
  } REQ;

  typedef struct packed {
    logic [31:0] RD;
    logic        RDV;
    logic        HOLD;
  } RES;

endpackage : pipe_sram_pkg

module pipe_sram_target
  import pipe_sram_pkg::*;
#(
  parameter int          ADDR_BITS   = 12,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE        = 32'hBFC00000
) (
  input  logic clock,
  input  logic rst_n,
  input  REQ   req,
  output RES   res
);

  localparam int          c_depth    = 1 << ADDR_BITS;
  localparam logic [3:0]  c_wait_m1  = 4'(WAIT_STATES - 1);
  localparam logic [31:0] c_oob_data = 32'hDEADBEEF;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_cnt;
  logic [3:0]           w_cnt_nxt;
  logic                 w_present;
  logic                 w_hold;
  logic                 w_accept;
  logic                 w_wr_en;
  logic                 w_rd_en;
  logic                 w_in_range;
  logic [ADDR_BITS-1:0] w_idx;
  logic [31:0]          r_rd;
  logic                 r_rdv;
  logic [31:0]          mem [c_depth];

  // The 4-bit wait counter cannot represent more than 15 wait states.
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("pipe_sram_target: WAIT_STATES must be in 0..15");
  end

  assign w_present = req.R | req.W;
  assign w_idx     = req.A[ADDR_BITS+1:2];

`ifdef PIPE_SRAM_BOUNDS_EN
  assign w_in_range = (req.A[31:ADDR_BITS+2] == BASE[31:ADDR_BITS+2]);
  logic w_unused_bits;
  assign w_unused_bits = ^req.A[1:0];
`else
  // Upper address bits are ignored: the RAM aliases across the address space.
  assign w_in_range = 1'b1;
  logic w_unused_bits;
  assign w_unused_bits = ^{req.A[31:ADDR_BITS+2], req.A[1:0]};
`endif

  // A simultaneous R and W is serviced as a write only.
  assign w_wr_en = w_accept & req.W & w_in_range;
  assign w_rd_en = w_accept & req.R & ~req.W;

  // State and wait-count register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, HOLD and acceptance decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hold      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_present) begin
          if (WAIT_STATES == 0) begin
            w_accept = 1'b1;
          end else begin
            w_hold      = 1'b1;
            w_cnt_nxt   = c_wait_m1;
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!w_present) begin
          // Initiator withdrew the request: abandon it without an access.
          w_cnt_nxt   = 4'd0;
          w_state_nxt = S_IDLE;
        end else if (r_cnt != 4'd0) begin
          w_hold    = 1'b1;
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_accept    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Byte-masked RAM write; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (req.WBE[b]) begin
          mem[w_idx][8*b +: 8] <= req.WD[8*b +: 8];
        end
      end
    end
  end

  // Registered read data and its one-cycle valid pulse; RD holds otherwise.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_rd  <= 32'd0;
      r_rdv <= 1'b0;
    end else begin
      r_rdv <= w_rd_en;
      if (w_rd_en) begin
        r_rd <= w_in_range ? mem[w_idx] : c_oob_data;
      end
    end
  end

  assign res.RD   = r_rd;
  assign res.RDV  = r_rdv;
  assign res.HOLD = w_hold;

endmodule : pipe_sram_target
`default_nettype wire
